// File: rtl/ofm_wb_pkg.sv
// Shared types and parameter helpers for the OFM write-back stage.
package ofm_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int half_of(input int sram_width);
    return sram_width / 2;
  endfunction

  function automatic int pairs_of(input int num_out);
    return num_out / 2;
  endfunction

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ofm_wb_if.sv
// CCU config, systolic-array lanes and GLB write port of the OFM write-back stage.
interface ofm_wb_if
  import ofm_wb_pkg::*;
#(
  parameter int SRAM_WIDTH = 256,
  parameter int NUM_OUT    = 4,
  parameter int ADDR_WIDTH = 16
);
  localparam int HALF = half_of(SRAM_WIDTH);

  logic                      CCUOWB_Rst;
  logic                      CCUOWB_CfgVld;
  logic                      OWBCCU_CfgRdy;
  logic [ADDR_WIDTH-1:0]     CCUOWB_CfgBase;
  logic [ADDR_WIDTH-1:0]     CCUOWB_CfgNum;
  logic [NUM_OUT*HALF-1:0]   SYAOWB_Ofm;
  logic [NUM_OUT-1:0]        SYAOWB_OfmVld;
  logic [NUM_OUT-1:0]        OWBSYA_OfmRdy;
  logic [ADDR_WIDTH-1:0]     OWBGLB_WrAddr;
  logic [SRAM_WIDTH-1:0]     OWBGLB_WrDat;
  logic                      OWBGLB_WrVld;
  logic                      GLBOWB_WrRdy;
  logic                      OWBCCU_Done;

  modport slave (
    input  CCUOWB_Rst, CCUOWB_CfgVld, CCUOWB_CfgBase, CCUOWB_CfgNum,
           SYAOWB_Ofm, SYAOWB_OfmVld, GLBOWB_WrRdy,
    output OWBCCU_CfgRdy, OWBSYA_OfmRdy, OWBGLB_WrAddr, OWBGLB_WrDat,
           OWBGLB_WrVld, OWBCCU_Done
  );

  modport master (
    output CCUOWB_Rst, CCUOWB_CfgVld, CCUOWB_CfgBase, CCUOWB_CfgNum,
           SYAOWB_Ofm, SYAOWB_OfmVld, GLBOWB_WrRdy,
    input  OWBCCU_CfgRdy, OWBSYA_OfmRdy, OWBGLB_WrAddr, OWBGLB_WrDat,
           OWBGLB_WrVld, OWBCCU_Done
  );

endinterface

// File: rtl/ofm_wb_fifo.sv
// Per-lane synchronous FIFO with registered occupancy and synchronous flush.
module ofm_wb_fifo
  import ofm_wb_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ofm_wb.sv
// OFM write-back: per-lane FIFOs, lane pairing, round-robin pair grant, addressed GLB writes.
// Optional stall-cycle counter output enabled by defining OFM_WB_STAT_EN.
module ofm_wb
  import ofm_wb_pkg::*;
#(
  parameter int SRAM_WIDTH = 256,
  parameter int NUM_OUT    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  ofm_wb_if.slave     bus
`ifdef OFM_WB_STAT_EN
  ,
  output logic [31:0] OWBCCU_StallCnt
`endif
);
  localparam int HALF     = half_of(SRAM_WIDTH);
  localparam int NUM_PAIR = pairs_of(NUM_OUT);
  localparam int RRW      = clog2_min1(NUM_PAIR);

  state_t                 state_reg;
  logic [ADDR_WIDTH-1:0]  base_reg;
  logic [ADDR_WIDTH-1:0]  num_reg;
  logic [ADDR_WIDTH-1:0]  issued_reg;
  logic [ADDR_WIDTH-1:0]  acked_reg;
  logic [RRW-1:0]         rr_reg;
  logic                   wr_vld_reg;
  logic [ADDR_WIDTH-1:0]  wr_addr_reg;
  logic [SRAM_WIDTH-1:0]  wr_dat_reg;

  logic [HALF-1:0]        head [NUM_OUT];
  logic [SRAM_WIDTH-1:0]  pair_dat [NUM_PAIR];
  logic [NUM_OUT-1:0]     fifo_full;
  logic [NUM_OUT-1:0]     fifo_empty;
  logic [NUM_OUT-1:0]     ofm_rdy;
  logic [NUM_OUT-1:0]     fifo_push;
  logic [NUM_OUT-1:0]     fifo_pop;
  logic [NUM_PAIR-1:0]    pair_rdy;
  logic                   flush;
  logic                   accept;
  logic                   can_issue;
  logic                   grant_vld;
  logic [RRW-1:0]         grant_idx;
  logic [RRW-1:0]         rr_next;

  assign flush     = bus.CCUOWB_Rst || (state_reg == ST_DONE);
  assign accept    = wr_vld_reg && bus.GLBOWB_WrRdy;
  assign can_issue = (state_reg == ST_RUN) && (issued_reg < num_reg)
                     && (!wr_vld_reg || bus.GLBOWB_WrRdy);

  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
      // Ready looks only at the registered occupancy, never at a same-cycle pop.
      assign ofm_rdy[gi]   = (state_reg == ST_RUN) && !fifo_full[gi];
      assign fifo_push[gi] = bus.SYAOWB_OfmVld[gi] && ofm_rdy[gi];
      assign fifo_pop[gi]  = grant_vld && (grant_idx == RRW'(gi / 2));

      ofm_wb_fifo #(.WIDTH(HALF), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (fifo_push[gi]),
        .din   (bus.SYAOWB_Ofm[gi*HALF +: HALF]),
        .pop   (fifo_pop[gi]),
        .head  (head[gi]),
        .full  (fifo_full[gi]),
        .empty (fifo_empty[gi])
      );
    end

    for (genvar gi = 0; gi < NUM_PAIR; gi++) begin : g_pair
      assign pair_rdy[gi] = !fifo_empty[2*gi] && !fifo_empty[2*gi+1];
      assign pair_dat[gi] = {head[2*gi+1], head[2*gi]};
    end
  endgenerate

  // Scan from the farthest offset down so the pair closest to rr wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int off = NUM_PAIR - 1; off >= 0; off--) begin
      idx = (int'(rr_reg) + off) % NUM_PAIR;
      if (can_issue && pair_rdy[idx]) begin
        grant_vld = 1'b1;
        grant_idx = RRW'(idx);
      end
    end
  end

  assign rr_next = (grant_idx == RRW'(NUM_PAIR - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      base_reg    <= '0;
      num_reg     <= '0;
      issued_reg  <= '0;
      acked_reg   <= '0;
      rr_reg      <= '0;
      wr_vld_reg  <= 1'b0;
      wr_addr_reg <= '0;
      wr_dat_reg  <= '0;
    end else if (bus.CCUOWB_Rst) begin
      state_reg   <= ST_IDLE;
      base_reg    <= '0;
      num_reg     <= '0;
      issued_reg  <= '0;
      acked_reg   <= '0;
      rr_reg      <= '0;
      wr_vld_reg  <= 1'b0;
      wr_addr_reg <= '0;
      wr_dat_reg  <= '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (bus.CCUOWB_CfgVld) begin
            base_reg   <= bus.CCUOWB_CfgBase;
            num_reg    <= bus.CCUOWB_CfgNum;
            issued_reg <= '0;
            acked_reg  <= '0;
            state_reg  <= (bus.CCUOWB_CfgNum == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (grant_vld) begin
            wr_vld_reg  <= 1'b1;
            wr_addr_reg <= base_reg + issued_reg;
            wr_dat_reg  <= pair_dat[grant_idx];
            issued_reg  <= issued_reg + 1'b1;
            rr_reg      <= rr_next;
          end else if (accept) begin
            wr_vld_reg <= 1'b0;
          end
          if (accept) begin
            acked_reg <= acked_reg + 1'b1;
            if (acked_reg + 1'b1 == num_reg) state_reg <= ST_DONE;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.OWBCCU_CfgRdy = (state_reg == ST_IDLE);
  assign bus.OWBCCU_Done   = (state_reg == ST_DONE);
  assign bus.OWBSYA_OfmRdy = ofm_rdy;
  assign bus.OWBGLB_WrVld  = wr_vld_reg;
  assign bus.OWBGLB_WrAddr = wr_addr_reg;
  assign bus.OWBGLB_WrDat  = wr_dat_reg;

`ifdef OFM_WB_STAT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (bus.CCUOWB_Rst || (state_reg == ST_IDLE && bus.CCUOWB_CfgVld)) begin
      stall_cnt_reg <= '0;
    end else if (wr_vld_reg && !bus.GLBOWB_WrRdy && stall_cnt_reg != '1) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign OWBCCU_StallCnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ofm_wb.sv
// Self-checking bench for ofm_wb: queue-based scoreboard, config table, directed corner sequences.
module tb_ofm_wb;
  import ofm_wb_pkg::*;

  localparam int SW = 256;
  localparam int NO = 4;
  localparam int AW = 16;
  localparam int FD = 4;
  localparam int HW = SW / 2;
  localparam int NP = NO / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofm_wb_if #(.SRAM_WIDTH(SW), .NUM_OUT(NO), .ADDR_WIDTH(AW)) bus ();
`ifdef OFM_WB_STAT_EN
  logic [31:0] stall_cnt;
`endif

  ofm_wb #(.SRAM_WIDTH(SW), .NUM_OUT(NO), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef OFM_WB_STAT_EN
    ,
    .OWBCCU_StallCnt (stall_cnt)
`endif
  );

  typedef struct {
    logic [AW-1:0] base;
    int            num;
    int            vld_pct;
    int            rdy_pct;
    int            exp_writes;
    logic [AW-1:0] exp_last;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: lane queues of accepted half-words and the expected write stream.
  logic [HW-1:0] lq [NO][$];
  logic [AW-1:0] m_base;
  int            m_num;
  int            m_acc;
  bit            exp_done;
  int            done_cnt = 0;
  int            done_cyc;
  int            log_pair[$];
  int            log_cyc[$];
  logic [AW-1:0] log_addr[$];
  logic [SW-1:0] log_dat[$];

  bit            hold_v = 1'b0;
  logic [AW-1:0] hold_a;
  logic [SW-1:0] hold_d;

  logic [HW-1:0] ldat[NO];
  int            lleft[NO];
  int            vld_pct = 100;
  int            rdy_pct = 100;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [HW-1:0] rnd_half();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NO; i++) lq[i].delete();
  endtask

  task automatic sb_accept();
    int k;
    k = -1;
    for (int p = NP - 1; p >= 0; p--) begin
      if (lq[2*p].size() > 0 && lq[2*p+1].size() > 0 &&
          {lq[2*p+1][0], lq[2*p][0]} == bus.OWBGLB_WrDat) k = p;
    end
    tests++;
    if (k < 0) begin
      fails++;
      $display("FAIL wr_data: got %0h expected a pair of lane heads (cycle %0d)", bus.OWBGLB_WrDat, cyc);
    end else begin
      void'(lq[2*k].pop_front());
      void'(lq[2*k+1].pop_front());
    end
    chk("wr_addr", bus.OWBGLB_WrAddr, AW'(m_base + AW'(m_acc)));
    chk("wr_count_in_range", (m_acc < m_num), 1'b1);
    $display("[TB] write addr=%04h pair=%0d cycle=%0d", bus.OWBGLB_WrAddr, k, cyc);
    log_pair.push_back(k);
    log_cyc.push_back(cyc);
    log_addr.push_back(bus.OWBGLB_WrAddr);
    log_dat.push_back(bus.OWBGLB_WrDat);
    m_acc++;
    if (m_acc == m_num) exp_done = 1'b1;
  endtask

  // One clock: check outputs, drive inputs, record handshakes, advance to next negedge.
  task automatic step();
    if (bus.OWBCCU_Done) begin
      chk("done_pulse", 1'b1, exp_done);
      done_cnt++;
      done_cyc = cyc;
      clear_model();
    end else if (exp_done) begin
      chk("done_pulse", 1'b0, 1'b1);
    end
    exp_done = 1'b0;
    if (hold_v) begin
      chk("hold_vld", bus.OWBGLB_WrVld, 1'b1);
      chk("hold_addr", bus.OWBGLB_WrAddr, hold_a);
      chk("hold_data", bus.OWBGLB_WrDat, hold_d);
    end
    for (int i = 0; i < NO; i++) begin
      bus.SYAOWB_OfmVld[i] = (lleft[i] > 0) && (int'($urandom_range(99)) < vld_pct);
      bus.SYAOWB_Ofm[i*HW +: HW] = ldat[i];
    end
    bus.GLBOWB_WrRdy = (int'($urandom_range(99)) < rdy_pct);
    hold_v = 1'b0;
    if (!bus.CCUOWB_Rst) begin
      for (int i = 0; i < NO; i++) begin
        if (bus.SYAOWB_OfmVld[i] && bus.OWBSYA_OfmRdy[i]) begin
          lq[i].push_back(ldat[i]);
          lleft[i]--;
          ldat[i] = rnd_half();
        end
      end
      if (bus.OWBGLB_WrVld) begin
        if (bus.GLBOWB_WrRdy) begin
          sb_accept();
        end else begin
          hold_v = 1'b1;
          hold_a = bus.OWBGLB_WrAddr;
          hold_d = bus.OWBGLB_WrDat;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_cfg(input logic [AW-1:0] base, input int num);
    chk("cfg_rdy", bus.OWBCCU_CfgRdy, 1'b1);
    bus.CCUOWB_CfgVld  = 1'b1;
    bus.CCUOWB_CfgBase = base;
    bus.CCUOWB_CfgNum  = AW'(num);
    m_base = base;
    m_num  = num;
    m_acc  = 0;
    log_pair.delete();
    log_cyc.delete();
    log_addr.delete();
    log_dat.delete();
    step();
    bus.CCUOWB_CfgVld = 1'b0;
    if (num == 0) exp_done = 1'b1;
    chk("ofm_rdy_after_cfg", bus.OWBSYA_OfmRdy, (num > 0) ? 4'hF : 4'h0);
  endtask

  task automatic run_done(input int limit);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < limit) begin
      step();
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic set_lanes(input int n);
    for (int i = 0; i < NO; i++) lleft[i] = n;
  endtask

  task automatic soft_rst();
    bus.CCUOWB_Rst = 1'b1;
    step();
    bus.CCUOWB_Rst = 1'b0;
    clear_model();
    hold_v = 1'b0;
    exp_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int c0;
    logic [SW-1:0] e_dat;
    int exp_pairs[6];

    tbl[0] = '{16'hFFFF,  3, 100, 100,  3, 16'h0001};
    tbl[1] = '{16'h0000,  0, 100, 100,  0, 16'h0000};
    tbl[2] = '{16'h0100, 20,  70,  60, 20, 16'h0113};
    tbl[3] = '{16'hFFFE,  5,  50,  80,  5, 16'h0002};
    tbl[4] = '{16'h1234,  1, 100,  30,  1, 16'h1234};
    tbl[5] = '{16'h0200, 40,  90,  90, 40, 16'h0227};
    exp_pairs = '{1, 0, 1, 0, 1, 0};

    bus.CCUOWB_Rst     = 1'b0;
    bus.CCUOWB_CfgVld  = 1'b0;
    bus.CCUOWB_CfgBase = '0;
    bus.CCUOWB_CfgNum  = '0;
    bus.SYAOWB_Ofm     = '0;
    bus.SYAOWB_OfmVld  = '0;
    bus.GLBOWB_WrRdy   = 1'b0;
    for (int i = 0; i < NO; i++) begin
      ldat[i]  = rnd_half();
      lleft[i] = 0;
    end

    repeat (2) @(negedge clk);
    chk("rst_cfg_rdy", bus.OWBCCU_CfgRdy, 1'b1);
    chk("rst_ofm_rdy", bus.OWBSYA_OfmRdy, 4'h0);
    chk("rst_wr_vld", bus.OWBGLB_WrVld, 1'b0);
    chk("rst_wr_addr", bus.OWBGLB_WrAddr, 16'h0);
    chk("rst_wr_dat", bus.OWBGLB_WrDat, '0);
    chk("rst_done", bus.OWBCCU_Done, 1'b0);
`ifdef OFM_WB_STAT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Basic pairing and latency: lane i presents i+1 once.
    vld_pct = 100;
    rdy_pct = 100;
    do_cfg(16'h0010, 2);
    for (int i = 0; i < NO; i++) begin
      ldat[i]  = HW'(i + 1);
      lleft[i] = 1;
    end
    c0 = cyc;
    step();
    chk("latency_wr_vld_low", bus.OWBGLB_WrVld, 1'b0);
    run_done(50);
    chk("s1_writes", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      e_dat = {HW'(2), HW'(1)};
      chk("s1_addr0", log_addr[0], 16'h0010);
      chk("s1_dat0", log_dat[0], e_dat);
      chk("s1_cyc0", log_cyc[0], c0 + 2);
      e_dat = {HW'(4), HW'(3)};
      chk("s1_addr1", log_addr[1], 16'h0011);
      chk("s1_dat1", log_dat[1], e_dat);
      chk("s1_cyc1", log_cyc[1], c0 + 3);
    end
    chk("s1_done_cyc", done_cyc, c0 + 4);
    chk("s1_cfg_rdy", bus.OWBCCU_CfgRdy, 1'b1);
    chk("s1_ofm_rdy_idle", bus.OWBSYA_OfmRdy, 4'h0);

    // Back-pressure: five stalled cycles with all lanes streaming.
    rdy_pct = 0;
    do_cfg(16'h0020, 12);
    set_lanes(1000);
    repeat (5) step();
    chk("stall_ofm_rdy_full", bus.OWBSYA_OfmRdy, 4'h0);
    chk("stall_lane0_pushed", lq[0].size(), 5);
    chk("stall_lane2_pushed", lq[2].size(), 4);
    repeat (2) step();
    chk("stall_ofm_rdy_hold", bus.OWBSYA_OfmRdy, 4'h0);
    rdy_pct = 100;
    run_done(200);
    set_lanes(0);
    chk("stall_writes", log_addr.size(), 12);
`ifdef OFM_WB_STAT_EN
    chk("stall_cnt", stall_cnt, 32'd5);
`endif

    // Round robin: pair 1 alone first, then both pairs streaming.
    soft_rst();
    do_cfg(16'h0040, 6);
    lleft[2] = 1;
    lleft[3] = 1;
    step();
    set_lanes(1000);
    run_done(100);
    set_lanes(0);
    chk("rr_writes", log_pair.size(), 6);
    for (int i = 0; i < 6 && i < log_pair.size(); i++) chk("rr_order", log_pair[i], exp_pairs[i]);

    // Soft clear mid-run with a write pending and accepted in the same cycle.
    rdy_pct = 0;
    do_cfg(16'h0080, 10);
    set_lanes(1000);
    repeat (4) step();
    chk("clr_wr_vld_before", bus.OWBGLB_WrVld, 1'b1);
    rdy_pct = 100;
    soft_rst();
    set_lanes(0);
    chk("clr_wr_vld", bus.OWBGLB_WrVld, 1'b0);
    chk("clr_ofm_rdy", bus.OWBSYA_OfmRdy, 4'h0);
    chk("clr_cfg_rdy", bus.OWBCCU_CfgRdy, 1'b1);
    chk("clr_no_done", bus.OWBCCU_Done, 1'b0);
    step();
    chk("clr_no_done_later", bus.OWBCCU_Done, 1'b0);
    do_cfg(16'h0090, 4);
    set_lanes(1000);
    run_done(100);
    set_lanes(0);
    chk("clr_rerun_writes", log_addr.size(), 4);
    if (log_addr.size() > 0) chk("clr_rerun_addr0", log_addr[0], 16'h0090);

    // Table of configurations under randomized valid/ready patterns.
    for (int t = 0; t < 6; t++) begin
      vld_pct = tbl[t].vld_pct;
      rdy_pct = tbl[t].rdy_pct;
      do_cfg(tbl[t].base, tbl[t].num);
      set_lanes(1000);
      run_done(3000);
      set_lanes(0);
      chk("tbl_writes", log_addr.size(), tbl[t].exp_writes);
      if (tbl[t].num > 0 && log_addr.size() > 0)
        chk("tbl_last_addr", log_addr[log_addr.size()-1], tbl[t].exp_last);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
